// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI-Lite initiator.
// Ports: req_*/rsp_* access port, m_axil_* AXI-Lite master, busy.
module axi_lite_master_bridge #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [2:0] AXPROT = 3'b000
) (
  input  logic                axil_aclk,
  input  logic                axil_aresetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  input  logic [1:0]          m_axil_bresp,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                req_ready_d;
  logic                rsp_valid_d;
  logic                rsp_we_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic [1:0]          rsp_resp_d;
  logic                busy_d;
  logic                awvalid_d;
  logic                wvalid_d;
  logic                bready_d;
  logic                arvalid_d;
  logic                rready_d;

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = AXPROT;
  assign m_axil_arprot = AXPROT;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_we_d    = rsp_we;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    busy_d      = busy;
    awvalid_d   = m_axil_awvalid;
    wvalid_d    = m_axil_wvalid;
    bready_d    = m_axil_bready;
    arvalid_d   = m_axil_arvalid;
    rready_d    = m_axil_rready;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          if (req_we) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W retire independently, in any order
        awvalid_d = m_axil_awvalid && !m_axil_awready;
        wvalid_d  = m_axil_wvalid && !m_axil_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (m_axil_bvalid && m_axil_bready) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axil_bresp;
        end
      end
      RD_AR: begin
        if (m_axil_arvalid && m_axil_arready) begin
          state_d   = RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_R: begin
        if (m_axil_rvalid && m_axil_rready) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
        end
      end
      RSP: begin
        // req_ready returns only after the consuming edge
        if (rsp_valid && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        addr_d      = '0;
        wdata_d     = '0;
        wstrb_d     = '0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = '0;
        rsp_resp_d  = '0;
        busy_d      = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_we         <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= '0;
      busy           <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      req_ready      <= req_ready_d;
      rsp_valid      <= rsp_valid_d;
      rsp_we         <= rsp_we_d;
      rsp_rdata      <= rsp_rdata_d;
      rsp_resp       <= rsp_resp_d;
      busy           <= busy_d;
      m_axil_awvalid <= awvalid_d;
      m_axil_wvalid  <= wvalid_d;
      m_axil_bready  <= bready_d;
      m_axil_arvalid <= arvalid_d;
      m_axil_rready  <= rready_d;
    end
  end

endmodule
